// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: frame state encoding,
// legal oversampling ratios and the sample-ready offset used by the
// sampler, the checkers and the frame sequencer.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_rx_state_e;

    // Legal PRESCALE (oversampling ratio) values
    localparam int unsigned PRESCALE_X8  = 8;
    localparam int unsigned PRESCALE_X16 = 16;
    localparam int unsigned PRESCALE_X32 = 32;

    // The sampled bit is valid SMP_RDY_OFS edges after mid-bit
    localparam int unsigned SMP_RDY_OFS = 2;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and bit counter for the UART receiver.
// PRESCALE is captured while disabled so the ratio stays fixed for the
// whole frame; both counters are held at zero while disabled.
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      CNT_EN,
    input  logic                      CNT_CLR,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    output logic [PRESCALE_WIDTH-1:0] EDGE_CNT,
    output logic [3:0]                BIT_CNT,
    output logic                      EDGE_LAST,
    output logic                      EDGE_PRE_SMP
);

    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [PRESCALE_WIDTH-1:0] last_edge;
    logic [PRESCALE_WIDTH-1:0] pre_smp_edge;

    assign last_edge    = prescale_q - PRESCALE_WIDTH'(1);
    // One edge before SMP_RDY, so registered strobes land on SMP_RDY
    assign pre_smp_edge = (prescale_q >> 1) + PRESCALE_WIDTH'(SMP_RDY_OFS - 1);
    assign EDGE_LAST    = (EDGE_CNT == last_edge);
    assign EDGE_PRE_SMP = (EDGE_CNT == pre_smp_edge);

    // Ratio capture while idle; edge count with wrap and bit advance while enabled
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prescale_q <= '0;
            EDGE_CNT   <= '0;
            BIT_CNT    <= '0;
        end else if (!CNT_EN) begin
            prescale_q <= PRESCALE;
            EDGE_CNT   <= '0;
            BIT_CNT    <= '0;
        end else if (CNT_CLR) begin
            EDGE_CNT   <= '0;
            BIT_CNT    <= '0;
        end else if (EDGE_LAST) begin
            EDGE_CNT   <= '0;
            BIT_CNT    <= BIT_CNT + 4'd1;
        end else begin
            EDGE_CNT   <= EDGE_CNT + PRESCALE_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver frame sequencer: detects the start edge, walks the frame
// through start/data/parity/stop bits, issues one-cycle sampling and
// check strobes, and flags error-free frames with a DATA_VALID pulse.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    input  logic                      STRT_GLITCH,
    input  logic                      PAR_ERR,
    input  logic                      STP_ERR,
    output logic                      DAT_SAMP_EN,
    output logic                      STRT_CHK_EN,
    output logic                      PAR_CHK_EN,
    output logic                      STP_CHK_EN,
    output logic                      DESER_EN,
    output logic [PRESCALE_WIDTH-1:0] EDGE_CNT,
    output logic [3:0]                BIT_CNT,
    output logic                      DATA_VALID
);

    uart_rx_state_e state_q;
    uart_rx_state_e state_nxt;
    logic           cnt_en;
    logic           cnt_clr;
    logic           edge_last;
    logic           edge_pre_smp;

    // Counters run outside IDLE; they restart at every frame boundary,
    // including the stop->start hand-over of back-to-back frames.
    assign cnt_en  = (state_q != ST_IDLE);
    assign cnt_clr = edge_last && ((state_nxt == ST_IDLE) || (state_q == ST_STOP));

    uart_rx_edge_bit_cnt #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_cnt (
        .CLK          (CLK),
        .RST          (RST),
        .CNT_EN       (cnt_en),
        .CNT_CLR      (cnt_clr),
        .PRESCALE     (PRESCALE),
        .EDGE_CNT     (EDGE_CNT),
        .BIT_CNT      (BIT_CNT),
        .EDGE_LAST    (edge_last),
        .EDGE_PRE_SMP (edge_pre_smp)
    );

    // Next-state decode; checker flags and PAR_EN are only looked at on the last edge of a bit
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:   if (!RX_IN)     state_nxt = ST_START;
            ST_START:  if (edge_last)  state_nxt = STRT_GLITCH ? ST_IDLE : ST_DATA;
            ST_DATA:   if (edge_last && (BIT_CNT == 4'(DATA_WIDTH)))
                                       state_nxt = PAR_EN ? ST_PARITY : ST_STOP;
            ST_PARITY: if (edge_last)  state_nxt = PAR_ERR ? ST_IDLE : ST_STOP;
            ST_STOP:   if (edge_last)  state_nxt = RX_IN ? ST_IDLE : ST_START;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    // State register and registered strobes (decoded one edge ahead of SMP_RDY)
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            DAT_SAMP_EN <= 1'b0;
            STRT_CHK_EN <= 1'b0;
            DESER_EN    <= 1'b0;
            PAR_CHK_EN  <= 1'b0;
            STP_CHK_EN  <= 1'b0;
            DATA_VALID  <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            DAT_SAMP_EN <= (state_nxt != ST_IDLE);
            STRT_CHK_EN <= (state_q == ST_START)  && edge_pre_smp;
            DESER_EN    <= (state_q == ST_DATA)   && edge_pre_smp;
            PAR_CHK_EN  <= (state_q == ST_PARITY) && edge_pre_smp;
            STP_CHK_EN  <= (state_q == ST_STOP)   && edge_pre_smp;
            DATA_VALID  <= (state_q == ST_STOP)   && edge_last && !STP_ERR;
        end
    end

endmodule
